// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control slice: opcode/funct codes, ALU encodings, enums.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    // Primary opcodes, ir[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes, ir[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    // ALU operation encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_ILL
    } iclass_t;

endpackage

// File: rtl/mctrl_decode.sv
// Instruction decoder: maps the latched instruction to its class and ALU/datapath selects.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow ir directly.
//
// Ports: ir (instruction register) in; iclass, alu_op, alu_src, reg_dst, wb_sel out.
module mctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     iclass,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        wb_sel
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = ir[31:26];
    assign funct         = ir[5:0];
    // register/immediate fields go straight to the datapath, not used for decode
    assign unused_fields = ^ir[25:6];

    always_comb begin
        iclass  = CLS_ILL;
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        reg_dst = 1'b0;
        wb_sel  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                iclass  = CLS_RTYPE;
                reg_dst = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    default: begin
                        iclass  = CLS_ILL;
                        reg_dst = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                iclass  = CLS_ADDI;
                alu_src = 1'b1;
            end
            OP_LW: begin
                iclass  = CLS_LW;
                alu_src = 1'b1;
                wb_sel  = 1'b1;
            end
            OP_SW: begin
                iclass  = CLS_SW;
                alu_src = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch over imem handshake, decode, then drive ALU/regfile/dmem/PC controls.
// Latency: R-type/ADDI/SW 4 cycles, LW 5 cycles with zero-wait memories; each wait cycle adds one.
// Backpressure: imem_req/dmem_req held until ack; WAIT_MAX unacked cycles -> sticky bus_err, ERR.
//
// Ports: CLK, RST_N (async active-low), run; imem_req/imem_ack/imem_rdata; ir;
//        dmem_req/dmem_we/dmem_ack; alu_op, alu_src, reg_we, reg_dst, wb_sel; pc_en, retire,
//        illegal, bus_err; cycle_cnt, inst_cnt (live only when MCTRL_PERF_CNT_EN is defined).
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             wb_sel,
    output logic             pc_en,
    output logic             retire,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    // Wait counter holds the number of unacked cycles already spent; the request
    // times out in the cycle where it would reach WAIT_MAX.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  wait_q, wait_d;
    logic        bus_err_q, bus_err_d;

    iclass_t     dec_cls;
    logic [1:0]  dec_alu_op;
    logic        dec_alu_src;
    logic        dec_reg_dst;
    logic        dec_wb_sel;

    state_t      boundary_st;
    logic        ctl_en;

    mctrl_decode u_decode (
        .ir      (ir_q),
        .iclass  (dec_cls),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .reg_dst (dec_reg_dst),
        .wb_sel  (dec_wb_sel)
    );

    // Instruction boundary: run is sampled only here, so a drop mid-instruction completes it.
    assign boundary_st = run ? ST_FETCH : ST_IDLE;

    // Datapath selects are only presented from EXEC through WB.
    assign ctl_en  = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
    assign alu_op  = ctl_en ? dec_alu_op  : ALU_ADD;
    assign alu_src = ctl_en & dec_alu_src;
    assign reg_dst = ctl_en & dec_reg_dst;
    assign wb_sel  = ctl_en & dec_wb_sel;

    assign ir      = ir_q;
    assign bus_err = bus_err_q;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wait_d    = '0;
        bus_err_d = bus_err_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        pc_en     = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run && !bus_err_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (dec_cls)
                    CLS_RTYPE, CLS_ADDI: state_d = ST_WB;
                    CLS_LW, CLS_SW:      state_d = ST_MEM;
                    default: begin
                        // skip the bad word: advance PC, no writes, no retire
                        illegal = 1'b1;
                        pc_en   = 1'b1;
                        state_d = boundary_st;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_cls == CLS_SW);
                if (dmem_ack) begin
                    if (dec_cls == CLS_SW) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary_st;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = boundary_st;
            end
            ST_ERR: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef MCTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        if ((state_q != ST_IDLE) && (state_q != ST_ERR)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (retire) inst_cnt_d = inst_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
`else
    assign cycle_cnt = '0;
    assign inst_cnt  = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit core. Fetches each instruction over an instruction-memory request/acknowledge handshake and latches it into an internal instruction register (IR).
- Decodes the 7-instruction subset and drives the register-file, ALU, data-memory and PC-enable controls state by state.
- Sits between the memories and the datapath (register file, ALU, PC).

Parameters:
- WAIT_MAX, 15: maximum number of cycles a memory request may stay unacknowledged before a bus error is raised (1..255).
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- run  in  1  1 = keep executing; 0 = stop at the next instruction boundary
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction fetch done; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  latched instruction, which drives the rs/rt/rd/imm fields into the datapath
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (SW) qualifier, valid while dmem_req=1
- dmem_ack  in  1  data memory access done
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- alu_src  out  1  0 = rt register, 1 = sign-extended ir[15:0]
- reg_we  out  1  register-file write strobe
- reg_dst  out  1  0 = rt is the destination, 1 = rd is the destination
- wb_sel  out  1  0 = ALU result, 1 = memory read data
- pc_en  out  1  one-cycle PC+4 advance pulse
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  one-cycle pulse on an unknown opcode or funct
- bus_err  out  1  sticky; set on a request timeout, cleared only by reset
- cycle_cnt  out  CNT_W  cycles spent outside IDLE (optional feature)
- inst_cnt  out  CNT_W  retired instruction count (optional feature)

Behaviour:
- Reset, asynchronous on RST_N=0:
  - state=IDLE, ir=0, wait counter=0.
  - Every output is 0, including bus_err and both counters.
  - Reset asserted mid-access abandons the access immediately; there is no completion pulse.
- Decode table:
  - R-type, opcode 000000, by funct: ADD 100000, SUB 100010, AND 100100, OR 100101.
  - ADDI 001000, LW 100011, SW 101011.
  - Any other opcode or funct is illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
- IDLE: if run=1 and bus_err=0, go to FETCH.
- FETCH:
  - imem_req=1, held until imem_ack; an acknowledge in the same cycle as the request is legal.
  - On ack: ir<=imem_rdata, go to DECODE.
- DECODE: single cycle; control outputs become valid from the next cycle.
- EXEC:
  - alu_op and alu_src are driven (LW/SW use ADD with alu_src=1).
  - R-type and ADDI go to WB; LW and SW go to MEM.
  - Illegal instruction: pulse illegal, pulse pc_en, no retire, no writes; then go to the boundary.
- MEM:
  - dmem_req=1; dmem_we=1 for SW only; hold until dmem_ack.
  - SW on ack: pulse pc_en and retire, go to the boundary.
  - LW on ack: go to WB.
- WB:
  - reg_we=1 for exactly one cycle; reg_dst=1 for R-type; wb_sel=1 for LW.
  - Pulse pc_en and retire, then go to the boundary.
- Boundary: next state is FETCH if run=1, else IDLE. Dropping run mid-instruction always completes the current instruction.
- alu_op, alu_src, reg_dst and wb_sel hold from EXEC through WB. In IDLE and FETCH they are 0.
- Latency with zero-wait memories: R-type, ADDI and SW take 4 cycles; LW takes 5 cycles.
- Timeout:
  - The wait counter counts cycles a request has been held in FETCH or MEM.
  - If WAIT_MAX cycles pass without an ack: set bus_err, drop the request, go to ERR.
  - ERR is terminal until reset.
- imem_ack and dmem_ack arriving without the matching request are ignored.

Optional Feature:
- Macro MCTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle in which state is not IDLE or ERR.
  - inst_cnt increments on each retire pulse.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: the ports remain present and are tied to 0; no counter flops are instantiated.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants and funct constants;
  - alu_op encodings;
  - the state enum;
  - the instruction-class enum (RTYPE, ADDI, LW, SW, ILL).
- Sub-module mctrl_decode: combinational mapping from ir to instruction class, alu_op, alu_src, reg_dst and wb_sel; instantiated once inside multicycle_ctrl.

Test Plan:
- ADD, zero-wait: run=1, imem_rdata=0x012A4020 (add $8,$9,$10), ack in the same cycle.
  - alu_op=00, reg_dst=1, reg_we pulses on cycle 4, retire pulses once, pc_en pulses once.
- LW with a 3-cycle dmem wait: imem_rdata=0x8D280004.
  - dmem_req is held 3 cycles with dmem_we=0, then WB with wb_sel=1 and reg_we=1.
  - Total 8 cycles.
- SW: imem_rdata=0xAD280004.
  - dmem_we=1, reg_we never asserts, retire on the ack cycle, 4 cycles total.
- Illegal instruction: imem_rdata=0xFC000000.
  - illegal pulses in EXEC, pc_en pulses, no reg_we and no retire, next FETCH follows.
- Timeout: WAIT_MAX=15, imem_ack held at 0.
  - bus_err rises on the 15th request cycle, imem_req drops, the block stays in ERR.
  - Asserting RST_N=0 clears bus_err.
- run=0 mid-LW and reset mid-FETCH:
  - With run=0 during the LW, the LW completes, then IDLE with no further imem_req.
  - RST_N=0 during FETCH drops all outputs asynchronously.
  - With MCTRL_PERF_CNT_EN defined, after 2 ADDs: inst_cnt=2, cycle_cnt=8.
